// File: rtl/deco_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : deco_bcd_pkg
// Brief    : Shared types, defaults and sizing helper for the BCD decoder.
// Revision : 1.0
// ============================================================================
package deco_bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int DEFAULT_IN_W = 4;

    // Decimal digit count of the largest IN_W-bit value, i.e. ceil(in_w*log10(2)).
    function automatic int min_digits(input int in_w);
        longint unsigned maxv;
        int              n;
        maxv = (64'd1 << in_w) - 64'd1;
        n    = 1;
        while (maxv >= 64'd10) begin
            maxv = maxv / 64'd10;
            n    = n + 1;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add3
// Brief    : Double-dabble correction cell: adds 3 to a digit of 5 or more.
// Revision : 1.0
// ============================================================================
module bcd_add3
    import deco_bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    bcd_digit_t sum;

    assign sum     = digit_i + 4'd3;
    assign digit_o = (digit_i >= 4'd5) ? sum : digit_i;

endmodule
`default_nettype wire

// File: rtl/deco_bcd.sv
`default_nettype none
// ============================================================================
// Module   : deco_bcd
// Brief    : Binary to packed-BCD converter, unrolled double dabble, 1-cycle latency.
// Revision : 1.0
// ============================================================================
module deco_bcd
    import deco_bcd_pkg::*;
#(
    parameter int IN_W   = DEFAULT_IN_W,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [IN_W-1:0]       data_in,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   data_out
);

    localparam int BCD_W = 4 * DIGITS;

    if (DIGITS < min_digits(IN_W)) begin : g_bad_digits
        $error("deco_bcd: DIGITS=%0d too small for IN_W=%0d", DIGITS, IN_W);
    end

    logic [BCD_W-1:0] stage [IN_W+1];
    // Bits shifted out of the top digit; always zero when DIGITS is adequate.
    logic [IN_W-1:0]  unused_msb;

    assign stage[0] = '0;

    for (genvar i = 0; i < IN_W; i++) begin : g_iter
        logic [BCD_W-1:0] corr;

        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            bcd_add3 u_add3 (
                .digit_i (stage[i][4*d +: 4]),
                .digit_o (corr[4*d +: 4])
            );
        end

        assign stage[i+1]    = {corr[BCD_W-2:0], data_in[IN_W-1-i]};
        assign unused_msb[i] = corr[BCD_W-1];
    end

    logic [BCD_W-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    // The mux keeps data_in out of the register entirely when in_valid is low.
    assign data_d  = in_valid ? stage[IN_W] : data_q;
    assign valid_d = in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_deco_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_deco_bcd
// Brief    : Self-checking bench for deco_bcd (default and IN_W=8/DIGITS=3).
// Revision : 1.0
// ============================================================================
module tb_deco_bcd;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  data_in;
    logic        out_valid;
    logic [7:0]  data_out;
    logic        in_valid8;
    logic [7:0]  data_in8;
    logic        out_valid8;
    logic [11:0] data_out8;

    int checks = 0;
    int errors = 0;

    logic [7:0]  q4 [$];
    logic [11:0] q8 [$];
    logic [7:0]  hold4;
    logic [11:0] hold8;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [22];

    deco_bcd u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid),
        .data_out  (data_out)
    );

    deco_bcd #(.IN_W(8), .DIGITS(3)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .data_in   (data_in8),
        .out_valid (out_valid8),
        .data_out  (data_out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] bcd_model(input int value);
        logic [11:0] r;
        int          v;
        r = '0;
        v = value;
        for (int k = 0; k < 3; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc4(input logic v, input logic [3:0] d, input logic [7:0] exp);
        logic [7:0] e;
        in_valid = v;
        data_in  = d;
        if (v) q4.push_back(exp);
        @(posedge clk);
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("data_out", {24'd0, data_out}, {24'd0, e});
            hold4 = e;
        end else begin
            chk("idle_valid", {31'd0, out_valid}, 32'd0);
            chk("hold_data", {24'd0, data_out}, {24'd0, hold4});
        end
    endtask

    task automatic cyc8(input logic v, input logic [7:0] d, input logic [11:0] exp);
        logic [11:0] e;
        in_valid8 = v;
        data_in8  = d;
        if (v) q8.push_back(exp);
        @(posedge clk);
        #1;
        if (q8.size() > 0) begin
            e = q8.pop_front();
            chk("out_valid8", {31'd0, out_valid8}, 32'd1);
            chk("data_out8", {20'd0, data_out8}, {20'd0, e});
            hold8 = e;
        end else begin
            chk("idle_valid8", {31'd0, out_valid8}, 32'd0);
            chk("hold_data8", {20'd0, data_out8}, {20'd0, hold8});
        end
    endtask

    initial begin
        logic [11:0] m;
        int          r;

        for (int i = 0; i < 16; i++) begin
            tbl[i].v   = 1'b1;
            tbl[i].d   = 4'(i);
            tbl[i].exp = {4'(i / 10), 4'(i % 10)};
        end
        tbl[16] = '{1'b1, 4'd9,  8'h09};
        tbl[17] = '{1'b1, 4'd10, 8'h10};
        tbl[18] = '{1'b1, 4'd15, 8'h15};
        tbl[19] = '{1'b0, 4'd3,  8'h00};
        tbl[20] = '{1'b1, 4'd0,  8'h00};
        tbl[21] = '{1'b1, 4'd11, 8'h11};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        data_in   = 4'd0;
        in_valid8 = 1'b0;
        data_in8  = 8'd0;
        hold4     = 8'h00;
        hold8     = 12'h000;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_data", {24'd0, data_out}, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data8", {20'd0, data_out8}, 32'd0);
        chk("reset_valid8", {31'd0, out_valid8}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Table: exhaustive back-to-back, boundaries, and one idle cycle.
        for (int k = 0; k < 22; k++)
            cyc4(tbl[k].v, tbl[k].d, tbl[k].exp);

        // Hold: accepted 7, then 12 presented with in_valid low.
        cyc4(1'b1, 4'd7,  8'h07);
        cyc4(1'b0, 4'd12, 8'h00);
        cyc4(1'b0, 4'bxxxx, 8'h00);
        chk("hold_no_x", {24'd0, data_out}, 32'h07);

        // Reset pulsed mid-cycle while 0x13 is showing.
        cyc4(1'b1, 4'd13, 8'h13);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        data_in  = 4'd5;
        #1;
        chk("async_rst_data", {24'd0, data_out}, 32'd0);
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_discard_data", {24'd0, data_out}, 32'd0);
        chk("rst_discard_valid", {31'd0, out_valid}, 32'd0);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        hold4    = 8'h00;
        q4.delete();
        cyc4(1'b0, 4'd9, 8'h00);
        cyc4(1'b1, 4'd4, 8'h04);
        cyc4(1'b0, 4'd2, 8'h00);

        // Wider instance: fixed corners then random values.
        hold8 = 12'h000;
        cyc8(1'b1, 8'd255, 12'h255);
        cyc8(1'b1, 8'd100, 12'h100);
        cyc8(1'b1, 8'd99,  12'h099);
        cyc8(1'b1, 8'd0,   12'h000);
        cyc8(1'b0, 8'd77,  12'h000);
        cyc8(1'b1, 8'd128, 12'h128);
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(255, 0));
            m = bcd_model(r);
            cyc8(1'b1, 8'(r), m);
        end
        cyc8(1'b0, 8'd1, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/deco_bcd.md
DECO_BCD -- requirements
Module: deco_bcd

Interface
REQ-001 The module SHALL have parameter IN_W, default 4, binary input width.
REQ-002 The module SHALL have parameter DIGITS, default 2, number of BCD output digits; DIGITS SHALL be at least ceil(IN_W*log10(2)).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit; when high, data_in is sampled this cycle.
REQ-006 The module SHALL have port data_in, input, IN_W bits, unsigned binary value.
REQ-007 The module SHALL have port out_valid, output, 1 bit; high for exactly one cycle per converted sample.
REQ-008 The module SHALL have port data_out, output, 4*DIGITS bits, packed BCD with the most significant digit in the top nibble.

Function
REQ-009 Conversion SHALL be data_out = BCD(data_in); with defaults, data_out = {4'h0, data_in} for 0..9 and {4'h1, data_in-10} for 10..15.
REQ-010 Conversion SHALL use shift-and-add-3 (double dabble): IN_W iterations, adding 3 to any digit >= 5 before each left shift, fully unrolled as combinational logic.
REQ-011 The conversion result SHALL be registered: a sample accepted at edge N appears on data_out with out_valid=1 after edge N (latency 1 cycle).
REQ-012 When in_valid is low at a rising edge, data_out SHALL hold its previous value and out_valid SHALL be 0.
REQ-013 Back-to-back in_valid SHALL produce back-to-back results, one per cycle, with no stall and no backpressure.
REQ-014 Every BCD nibble of data_out SHALL always be in 0..9; unused upper digits SHALL be 0.
REQ-015 No input value SHALL cause overflow; all 2^IN_W values are representable given REQ-002.
REQ-016 data_in SHALL be ignored when in_valid is low; X on data_in with in_valid low SHALL NOT propagate.

Reset
REQ-017 On rst_n low, data_out SHALL become all zeros and out_valid SHALL become 0 immediately, without waiting for a clock edge.
REQ-018 While rst_n is low, in_valid SHALL be ignored; a sample presented in the same cycle that reset asserts SHALL be discarded.
REQ-019 After rst_n deasserts, the first in_valid at a rising edge SHALL be converted normally with 1-cycle latency.

Structure
REQ-020 Package deco_bcd_pkg SHALL hold typedef bcd_digit_t (4-bit logic), constant DEFAULT_IN_W=4, and function min_digits(in_w) used to check DIGITS at elaboration.
REQ-021 Elaboration SHALL fail with an error if DIGITS < min_digits(IN_W).
REQ-022 The add-3 correction cell SHALL be a sub-module bcd_add3 (4-bit in; out = in+3 if in >= 5, else in), instantiated per digit per iteration via generate.

Verification
REQ-023 Exhaustive test: in_valid=1 with data_in = 0..15 on consecutive cycles SHALL produce data_out = 0x00..0x09, 0x10..0x15, each one cycle later with out_valid=1.
REQ-024 Boundary test: data_in=9 SHALL produce 0x09, data_in=10 SHALL produce 0x10, and data_in=15 SHALL produce 0x15.
REQ-025 Hold test: data_in=7 with in_valid=1, then data_in=12 with in_valid=0 SHALL hold data_out=0x07 with out_valid=0.
REQ-026 Reset test: rst_n pulsed low between clock edges while data_out=0x13 SHALL immediately give data_out=0x00 and out_valid=0; after release, data_in=4 SHALL give 0x04.
REQ-027 Parameter test: IN_W=8, DIGITS=3, data_in=255 SHALL give 0x255; data_in=100 SHALL give 0x100.
